// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared region/DMA enums, bus constants and the CPU address decode.
package cpu_bus_pkg;
   typedef enum logic [2:0] {REG_RAM, REG_PPU, REG_DMA, REG_ROM, REG_NONE} region_t;
   typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_RD, DMA_WR} dma_state_t;
   localparam logic [15:0] ADDR_OAMDMA = 16'h4014;
   localparam logic [2:0] PPU_OAMDATA = 3'd4;
   function automatic region_t decode(input logic [15:0] a);
      return a[15] ? REG_ROM :
             a[14:13] == 2'b00 ? REG_RAM :
             a[14:13] == 2'b01 ? REG_PPU :
             a == ADDR_OAMDMA ? REG_DMA : REG_NONE;
   endfunction
endpackage

// File: rtl/cpu_bus_target_wram.sv
// wram: single-port 2^AW x 8 work RAM, registered read, write-first.
module wram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata <= wdata;
      end else
         rdata <= mem[addr];
   end
endmodule

// File: rtl/cpu_bus_target.sv
// cpu_bus_target: NES CPU-side bus responder with address decode, open bus and $4014 OAM DMA.
module cpu_bus_target
   import cpu_bus_pkg::*;
#(
   parameter int RAM_AW = 11,
   parameter int ROM_AW = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_write,
   input  logic [7:0]        cpu_dout,
   output logic [7:0]        cpu_din,
   output logic              cpu_ready,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              ppu_cs,
   output logic              ppu_we,
   output logic [2:0]        ppu_reg,
   output logic [7:0]        ppu_wdata,
   input  logic [7:0]        ppu_rdata
);
   dma_state_t  state;
   region_t     region, rd_reg;
   logic [7:0]  page, count, ram_q, open_bus, din_q, rd_data;
   logic [15:0] bus_addr;
   logic        cpu_owner, live, ram_we;
   always_comb begin
      cpu_owner = state == DMA_IDLE;
      bus_addr = cpu_owner ? cpu_addr : {page, count};
      region = decode(bus_addr);
      ram_we = cpu_owner && cpu_write && region == REG_RAM;
      rd_data = rd_reg == REG_RAM ? ram_q :
                rd_reg == REG_ROM ? rom_data :
                rd_reg == REG_PPU ? ppu_rdata : open_bus;
      // live: previous cycle belonged to the CPU, otherwise hold the last value seen
      cpu_din = live ? rd_data : din_q;
      rom_addr = bus_addr[ROM_AW-1:0];
      ppu_cs = !reset && (state == DMA_WR || ((cpu_owner || state == DMA_RD) && region == REG_PPU));
      ppu_we = !reset && (state == DMA_WR || (cpu_owner && cpu_write && region == REG_PPU));
      ppu_reg = state == DMA_WR ? PPU_OAMDATA : bus_addr[2:0];
      ppu_wdata = state == DMA_WR ? rd_data : cpu_dout;
   end
   wram #(.AW(RAM_AW)) u_wram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (bus_addr[RAM_AW-1:0]),
      .wdata (cpu_dout),
      .rdata (ram_q)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DMA_IDLE;
         cpu_ready <= 1'b1;
         page <= '0;
         count <= '0;
         rd_reg <= REG_NONE;
         live <= 1'b0;
         din_q <= '0;
         open_bus <= '0;
      end else begin
         rd_reg <= cpu_owner && cpu_write ? REG_NONE : region;
         live <= cpu_owner;
         din_q <= cpu_din;
         open_bus <= cpu_owner && cpu_write ? cpu_dout : live ? rd_data : open_bus;
         case (state)
            DMA_IDLE:
               if (cpu_write && cpu_addr == ADDR_OAMDMA) begin
                  page <= cpu_dout;
                  count <= '0;
                  state <= DMA_ALIGN;
                  cpu_ready <= 1'b0;
               end
            DMA_ALIGN: state <= DMA_RD;
            DMA_RD:    state <= DMA_WR;
            DMA_WR: begin
               count <= count + 8'd1;
               state <= count == 8'hff ? DMA_IDLE : DMA_RD;
               cpu_ready <= count == 8'hff;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_bus_target.sv
// tb_cpu_bus_target: vector table, randomized reference-model run and OAM DMA sequences.
module tb_cpu_bus_target;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_write;
   logic [7:0]  cpu_dout, cpu_din, rom_data, ppu_wdata, ppu_rdata;
   logic        cpu_ready, ppu_cs, ppu_we;
   logic [14:0] rom_addr;
   logic [2:0]  ppu_reg;

   cpu_bus_target #(.RAM_AW(11), .ROM_AW(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_write (cpu_write),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .cpu_ready (cpu_ready),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ppu_cs    (ppu_cs),
      .ppu_we    (ppu_we),
      .ppu_reg   (ppu_reg),
      .ppu_wdata (ppu_wdata),
      .ppu_rdata (ppu_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [14:0] a);
      return a[7:0] ^ {1'b0, a[14:8]};
   endfunction

   // external ROM and PPU both answer one cycle after the request
   always @(posedge clk) begin
      rom_data <= rom_fn(rom_addr);
      if (ppu_cs && !ppu_we) ppu_rdata <= 8'h82 ^ {5'd0, ppu_reg};
   end

   int          checks = 0, failures = 0;
   int          nw, bad, derr, kk, extra;
   logic [7:0]  mem [2048];
   logic [7:0]  open_m, s_din, s_wdata;
   logic        s_cs, s_we, s_ready;
   logic [2:0]  s_reg;
   logic [14:0] s_rom;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d);
      cpu_addr = a;
      cpu_write = w;
      cpu_dout = d;
      @(negedge clk);
      s_din = cpu_din;
      s_cs = ppu_cs;
      s_we = ppu_we;
      s_reg = ppu_reg;
      s_wdata = ppu_wdata;
      s_ready = cpu_ready;
      s_rom = rom_addr;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] src_byte(input logic [7:0] pg, input int i);
      return pg[7] ? rom_fn({pg[6:0], 8'(i)}) : mem[{pg[2:0], 8'(i)}];
   endfunction

   // trigger a DMA from page pg while the CPU hammers RAM, PPU and $4014; optional reset at byte stop_at
   task automatic dma_run(input logic [7:0] pg, input int stop_at);
      logic [7:0] r;
      cyc(16'h4014, 1'b1, pg);
      nw = 0;
      bad = 0;
      derr = 0;
      kk = 0;
      while (kk < 600) begin
         kk++;
         r = 8'($urandom);
         if (stop_at >= 0 && nw == stop_at) reset = 1'b1;
         if (reset || kk > 513) cyc(16'h0000, 1'b0, 8'h00);
         else if (kk % 3 == 0) cyc({8'h0A, r}, 1'b1, r);
         else if (kk % 3 == 1) cyc(16'h2004, 1'b1, r);
         else cyc(16'h4014, 1'b1, r);
         if (s_cs && s_we && s_reg == 3'd4) begin
            if (s_wdata !== src_byte(pg, nw)) derr++;
            nw++;
         end else if (s_cs) bad++;
         if (reset) begin
            reset = 1'b0;
            break;
         end
         if (s_ready) break;
      end
   endtask

   typedef struct packed {
      logic [15:0] a;
      logic        w;
      logic [7:0]  d;
      logic        cd;
      logic [7:0]  din;
      logic        cs;
      logic        we;
      logic [2:0]  rg;
   } vec_t;
   vec_t tv [17];

   initial begin
      #400000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0]  = '{16'h0123, 1'b1, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[1]  = '{16'h0923, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[2]  = '{16'h1923, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0};
      tv[3]  = '{16'h8042, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0};
      tv[4]  = '{16'h8042, 1'b1, 8'h99, 1'b1, 8'h42, 1'b0, 1'b0, 3'd0};
      tv[5]  = '{16'h8042, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[6]  = '{16'h3FFD, 1'b1, 8'hA5, 1'b1, 8'h42, 1'b1, 1'b1, 3'd5};
      tv[7]  = '{16'h2002, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2};
      tv[8]  = '{16'h0000, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 3'd0};
      tv[9]  = '{16'h5000, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[10] = '{16'h4000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[11] = '{16'h4014, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 3'd0};
      tv[12] = '{16'h0123, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 3'd0};
      tv[13] = '{16'h0000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0};
      tv[14] = '{16'h0456, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[15] = '{16'h0456, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tv[16] = '{16'h0000, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 3'd0};
      reset = 1'b1;
      cpu_addr = '0;
      cpu_write = 1'b0;
      cpu_dout = '0;
      @(posedge clk);
      #1;
      cyc(16'h2001, 1'b1, 8'hFF);
      chk("rst_ppu_cs", s_cs, 0);
      chk("rst_ppu_we", s_we, 0);
      chk("rst_ready", s_ready, 1);
      reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cyc(tv[i].a, tv[i].w, tv[i].d);
         chk($sformatf("vec%0d_ppu_cs", i), s_cs, tv[i].cs);
         chk($sformatf("vec%0d_ppu_we", i), s_we, tv[i].we);
         chk($sformatf("vec%0d_ready", i), s_ready, 1);
         if (tv[i].we) begin
            chk($sformatf("vec%0d_ppu_reg", i), s_reg, tv[i].rg);
            chk($sformatf("vec%0d_ppu_wdata", i), s_wdata, tv[i].d);
         end
         if (tv[i].cd) chk($sformatf("vec%0d_cpu_din", i), s_din, tv[i].din);
         if (tv[i].a[15]) chk($sformatf("vec%0d_rom_addr", i), s_rom, tv[i].a[14:0]);
      end
      for (int i = 0; i < 256; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         cyc({8'h00, 8'(i)}, 1'b1, d);
         mem[i] = d;
         open_m = d;
      end
      begin
         logic       exp_v;
         logic [7:0] exp_d;
         exp_v = 1'b0;
         exp_d = '0;
         for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic        w;
            logic [7:0]  d, v;
            int          sel;
            sel = $urandom_range(0, 3);
            d = 8'($urandom);
            w = $urandom_range(0, 2) == 0;
            a = sel == 0 ? {3'b000, 2'($urandom), 3'b000, 8'($urandom)} :
                sel == 1 ? {3'b001, 13'($urandom)} :
                sel == 2 ? {1'b1, 15'($urandom)} : {2'b01, 14'($urandom)};
            if (a == 16'h4014) a = 16'h4015;
            cyc(a, w, d);
            if (exp_v) chk("rnd_cpu_din", s_din, exp_d);
            chk("rnd_ppu_cs", s_cs, sel == 1);
            chk("rnd_ppu_we", s_we, sel == 1 && w);
            if (sel == 1 && w) begin
               chk("rnd_ppu_reg", s_reg, a[2:0]);
               chk("rnd_ppu_wdata", s_wdata, d);
            end
            if (sel == 2) chk("rnd_rom_addr", s_rom, a[14:0]);
            if (w) begin
               open_m = d;
               if (sel == 0) mem[a[10:0]] = d;
               exp_v = 1'b0;
            end else begin
               v = sel == 0 ? mem[a[10:0]] : sel == 1 ? 8'h82 ^ {5'd0, a[2:0]} :
                   sel == 2 ? rom_fn(a[14:0]) : open_m;
               open_m = v;
               exp_d = v;
               exp_v = 1'b1;
            end
         end
      end
      for (int i = 0; i < 256; i++) begin
         cyc(16'h0200 + 16'(i), 1'b1, 8'(i));
         mem[11'h200 + 11'(i)] = 8'(i);
      end
      dma_run(8'h02, -1);
      chk("dma_ready_cycles", kk, 514);
      chk("dma_writes", nw, 256);
      chk("dma_data_errors", derr, 0);
      chk("dma_stray_ppu", bad, 0);
      cyc(16'h0A05, 1'b0, 8'h00);
      cyc(16'h0000, 1'b0, 8'h00);
      chk("post_dma_ram", s_din, 8'h05);
      dma_run(8'hFF, -1);
      chk("dmaff_ready_cycles", kk, 514);
      chk("dmaff_writes", nw, 256);
      chk("dmaff_data_errors", derr, 0);
      chk("dmaff_stray_ppu", bad, 0);
      dma_run(8'h02, 100);
      chk("dmarst_writes", nw, 100);
      chk("dmarst_data_errors", derr, 0);
      chk("dmarst_stray_ppu", bad, 0);
      cyc(16'h0000, 1'b0, 8'h00);
      chk("dmarst_ready", s_ready, 1);
      extra = int'(s_cs);
      repeat (4) begin
         cyc(16'h0000, 1'b0, 8'h00);
         extra += int'(s_cs);
      end
      chk("dmarst_no_strobes", extra, 0);
      dma_run(8'h02, -1);
      chk("restart_ready_cycles", kk, 514);
      chk("restart_writes", nw, 256);
      chk("restart_data_errors", derr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_bus_target.md
# cpu_bus_target

Bus responder on the 6502 CPU side of the NES. It answers the CPU's addr/write/d_out/d_in bus with one-cycle read latency, which matches the CPU's timing: data for the address driven in cycle t is consumed in cycle t+1. It decodes the CPU address map into mirrored 2 KB work RAM, the PPU register window, and PRG ROM. It also implements the $4014 OAM DMA engine, which takes over the bus and stalls the CPU through `cpu_ready`.

## Interface
Parameters:
- RAM_AW, 11, work RAM address width (2 KB, mirrored through $0000-$1FFF)
- ROM_AW, 15, PRG ROM address width (32 KB at $8000-$FFFF)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_write  in  1  CPU write strobe
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  read data to CPU, registered
- cpu_ready  out  1  low while DMA owns the bus
- rom_addr  out  ROM_AW  PRG ROM address, combinational
- rom_data  in  8  ROM data, valid one cycle after rom_addr
- ppu_cs  out  1  PPU register access this cycle
- ppu_we  out  1  PPU register write
- ppu_reg  out  3  PPU register index (address[2:0])
- ppu_wdata  out  8  PPU write data
- ppu_rdata  in  8  PPU read data, valid one cycle after ppu_cs

## Operation
- Reset: DMA FSM to IDLE, cpu_ready=1, cpu_din=0, open-bus latch=0, ppu_cs=0, ppu_we=0. RAM contents are not reset.
- Bus owner: the CPU in IDLE, the DMA engine otherwise. While the DMA engine owns the bus, all CPU inputs are ignored.
- Address decode, shared by the CPU and DMA paths:
  - $0000-$1FFF: RAM, index addr[RAM_AW-1:0].
  - $2000-$3FFF: PPU, ppu_reg=addr[2:0].
  - $4014: DMA trigger, write-only.
  - $8000-$FFFF: ROM, rom_addr=addr[ROM_AW-1:0].
  - All other addresses are unmapped.
- Reads: the decoded region is registered together with the access. On the next cycle cpu_din muxes RAM output, rom_data or ppu_rdata by that registered region. An unmapped or $4014 read returns the open-bus latch.
- Open-bus latch: holds the last byte placed on the data bus, either a read result or cpu_dout on any write.
- Writes:
  - RAM is written at the end of the cycle.
  - PPU writes drive ppu_cs=ppu_we=1 and ppu_wdata=cpu_dout in the same cycle.
  - ROM and unmapped writes are dropped.
- DMA FSM: IDLE -> ALIGN -> RD -> WR -> RD ... -> IDLE.
  - IDLE: a CPU write to $4014 with value N latches page N and clears the 8-bit count. The next state is ALIGN and cpu_ready goes low.
  - ALIGN: one idle cycle.
  - RD: drives source address {N, count} through the decode. A PPU-region source reads the PPU (ppu_cs=1, ppu_we=0).
  - WR: takes the fetched byte (available this cycle) and drives ppu_cs=ppu_we=1, ppu_reg=4, ppu_wdata=byte. It then increments count. If count was 255, the next state is IDLE, otherwise RD.
  - The total transfer is 513 cycles with cpu_ready low. cpu_ready returns to 1 on the cycle after the final WR.
- During DMA, cpu_din holds its last value.

## Timing
- RAM/ROM/PPU read: address in cycle t, data on cpu_din in cycle t+1.
- Write then read of the same RAM address in consecutive cycles: the read returns the new data.
- Trigger write in cycle t: cpu_ready=0 from t+1 through t+513, and cpu_ready=1 at t+514.
- Trigger write while not IDLE: impossible, because CPU inputs are ignored while the DMA engine owns the bus.
- Count wraps 255 -> 0 exactly at termination; no 257th transfer.
- Page N=$FF: the source is $FF00-$FFFF (ROM). This is legal.
- Reset mid-DMA: IDLE and cpu_ready=1 on the next cycle. No further PPU write strobes.
- ppu_cs/ppu_we are never asserted for two owners in the same cycle.

## Structure
- Package cpu_bus_pkg holds:
  - region enum {REG_RAM, REG_PPU, REG_DMA, REG_ROM, REG_NONE}
  - DMA state enum {DMA_IDLE, DMA_ALIGN, DMA_RD, DMA_WR}
  - constants ADDR_OAMDMA=16'h4014 and PPU_OAMDATA=3'd4
- Sub-module wram: single-port synchronous RAM, 2^RAM_AW x 8, registered read, write-first.
- The top level contains the decode, the registered read mux, the open-bus latch and the DMA FSM.

## Test plan
- RAM mirror: write $55 to $0123, read $0923 and $1923 -> cpu_din=$55 one cycle after each read address.
- ROM read: rom model returns addr[7:0]; read $8042 -> rom_addr=$0042, cpu_din=$42 next cycle. Write to $8042 -> no effect.
- PPU window: write $A5 to $3FFD -> ppu_cs=ppu_we=1, ppu_reg=5, ppu_wdata=$A5 the same cycle. A read of $2002 with ppu_rdata=$80 -> cpu_din=$80.
- Open bus: write $3C to $5000, then read $4000 -> cpu_din=$3C.
- DMA: preload RAM $0200-$02FF with i, write $02 to $4014 -> cpu_ready low for 513 cycles. Expect 256 PPU writes with ppu_reg=4 and data 0..255 in order, and no CPU-initiated PPU or RAM accesses during the transfer.
- Reset at DMA byte 100 -> cpu_ready=1 next cycle, exactly 100 OAM writes observed, FSM IDLE. A new $4014 write restarts at byte 0.
